qpsk_llr_demapper: RTL
======================

// Module: qpsk_llr_demapper
// PURPOSE
//  Soft QPSK demapper in front of the receive FEC chain. Takes equalised I/Q symbols, scales,
//  rounds and saturates each rail to a 5-bit signed LLR, buffers them and serialises them as one
//  LLR per cycle (I first, then Q) into DeFEC's idat/ival/ordy interface.
//  LLR sign convention: positive = bit 0. I -> even bit, Q -> odd bit.
// PARAMETERS
//  pIQ_W        12  signed width of the I and Q input samples
//  pLLR_W       5   signed LLR width (must equal DeFEC idat width)
//  pFIFO_DEPTH  4   symbol FIFO depth in I/Q pairs, power of 2, >= 2
// PORTS
//  clk          in   1         single clock
//  rst          in   1         asynchronous, active-low reset
//  isample_i    in   pIQ_W     I sample, signed
//  isample_q    in   pIQ_W     Q sample, signed
//  isample_val  in   1         sample valid
//  osample_rdy  out  1         demapper can accept a symbol
//  ishift       in   3         right-shift scale 0..7, sampled with each accepted symbol
//  irdy         in   1         downstream ready (DeFEC ordy)
//  oval         out  1         LLR valid (to DeFEC ival)
//  odat         out  pLLR_W    LLR, signed (to DeFEC idat)
//  iclr_stat    in   1         synchronous clear of the statistics counters
//  ostat_sym    out  16        accepted-symbol count, saturates at 16'hFFFF
//  ostat_sat    out  16        saturated-LLR count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst low, asynchronous): osample_rdy=0, oval=0, odat=0, ostat_*=0, FIFO empty, state S_I.
//    osample_rdy goes to 1 on the first clock after rst is released.
//  Input accept: a symbol is accepted in any cycle with isample_val & osample_rdy.
//    osample_rdy = (fifo_count + stage1_valid) < pFIFO_DEPTH, registered, so no accepted symbol is
//    ever dropped.
//  Stage 1 (1 cycle) computes, per rail, in pIQ_W+1 bits:
//    x = shift ? (s + 2^(shift-1)) >>> shift : s   (round half up)
//    llr = clip(x, -15, +15)   (symmetric range; -16 is never produced)
//    The result is written to the FIFO on the next edge.
//  Serialiser FSM:
//    S_I: oval = !fifo_empty, odat = head.I. On oval & irdy -> S_Q.
//    S_Q: oval = 1, odat = head.Q. On irdy -> pop FIFO and go to S_I.
//  Output stability: odat is stable while oval & !irdy.
//    irdy low in S_Q holds the Q LLR; the pair is never split or reordered.
//  Latency: symbol accepted at edge N with empty FIFO and irdy=1 -> I LLR valid after edge N+2,
//    Q after edge N+3.
//  Throughput: 1 symbol per 2 cycles sustained. osample_rdy throttles input accordingly.
//  Simultaneous FIFO write and pop in the same cycle: count unchanged. This is legal at full.
//  FIFO pointers wrap modulo pFIFO_DEPTH.
//  Statistics:
//    ostat_sym increments per accepted symbol.
//    ostat_sat increments by 0, 1 or 2 per symbol: one per rail clipped, counted at stage 1.
//    Both counters stick at 16'hFFFF.
//    iclr_stat wins over a same-cycle increment.
//  Reset mid-stream: FIFO contents and any partially sent pair are discarded.
//    The first LLR after reset is the I of the next accepted symbol.
// STRUCTURE
//  Package qpsk_demap_pkg:
//    typedef logic signed [pLLR_W-1:0] llr_t
//    struct llr_pair_t {llr_t i, q}
//    localparam cLLR_MAX = 2**(pLLR_W-1)-1
//    enum {S_I, S_Q}
//  One sub-module, demap_sym_fifo: synchronous FIFO of llr_pair_t, depth pFIFO_DEPTH, with count,
//    first-word-fall-through, same-cycle read and write.
//  Scaling and FSM stay in the top module.
// TESTING
//  ishift=0, I=-20, Q=3 -> odat -15 then +3, ostat_sat=1, ostat_sym=1.
//  ishift=2, I=6, Q=-6 -> odat +2 then -1 (round half up). ishift=4, I=256, Q=-96 -> +15, -6.
//  irdy=0 with 6 symbols offered back to back -> osample_rdy low after 4 accepted.
//    Then irdy=1 -> 8 LLRs, one per cycle, in order, then remaining 2 symbols follow.
//  irdy dropped for 3 cycles while in S_Q -> odat holds the Q value and oval stays 1;
//    the next LLR is the next symbol's I.
//  rst pulsed low with 3 symbols buffered -> oval=0 and ostat_*=0 immediately.
//    After release, a new symbol I=40, Q=-40 with ishift=3 -> +5, -5.
//  Preload ostat_sym near 16'hFFFF -> it stops at 16'hFFFF.
//    iclr_stat together with an accepted symbol -> 0.

Source files
------------

// File: rtl/qpsk_llr_demapper_pkg.sv
// Shared types for the QPSK soft demapper: LLR word, I/Q LLR pair, serialiser states
// and a saturating statistics adder.
package qpsk_llr_demapper_pkg;

  localparam int cLLR_W   = 5;
  localparam int cLLR_MAX = 2**(cLLR_W-1) - 1;

  typedef logic signed [cLLR_W-1:0] llr_t;

  typedef struct packed {
    llr_t i;
    llr_t q;
  } llr_pair_t;

  typedef enum logic {S_I, S_Q} ser_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] stat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/qpsk_llr_demapper_if.sv
// Demapper data link: I/Q symbol input with valid/ready, and the serial LLR output.
// slave is the demapper; master is its environment (symbol source and LLR sink).
interface qpsk_llr_demapper_if #(
  parameter int pIQ_W  = 12,
  parameter int pLLR_W = 5
);
  logic signed [pIQ_W-1:0]  isample_i;
  logic signed [pIQ_W-1:0]  isample_q;
  logic                     isample_val;
  logic                     osample_rdy;
  logic [2:0]               ishift;
  logic                     irdy;
  logic                     oval;
  logic signed [pLLR_W-1:0] odat;

  modport master (
    output isample_i, isample_q, isample_val, ishift, irdy,
    input  osample_rdy, oval, odat
  );

  modport slave (
    input  isample_i, isample_q, isample_val, ishift, irdy,
    output osample_rdy, oval, odat
  );
endinterface

// File: rtl/qpsk_llr_demapper_sym_fifo.sv
// First-word-fall-through FIFO of I/Q LLR pairs with occupancy count and a peek at the
// entry behind the head, so the serialiser can move to the next symbol without a bubble.
module qpsk_llr_demapper_sym_fifo
  import qpsk_llr_demapper_pkg::*;
#(
  parameter int pDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  llr_pair_t                 wr_data,
  input  logic                      rd_en,
  output llr_pair_t                 rd_data,
  output llr_pair_t                 rd_next,
  output logic [$clog2(pDEPTH):0]   count,
  output logic                      empty
);
  localparam int AW = $clog2(pDEPTH);

  llr_pair_t       mem [pDEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Power-of-two depth: pointers wrap by plain binary overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign rd_next = mem[rd_ptr_reg + AW'(1)];
  assign count   = count_reg;
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/qpsk_llr_demapper.sv
// Soft QPSK demapper: scales, rounds and clips each rail to a 5-bit LLR, buffers the
// pairs and serialises them I then Q, one LLR per cycle, into the FEC input handshake.
module qpsk_llr_demapper
  import qpsk_llr_demapper_pkg::*;
#(
  parameter int pIQ_W       = 12,
  parameter int pLLR_W      = cLLR_W,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  qpsk_llr_demapper_if.slave        bus,
  input  logic                      iclr_stat,
  output logic [15:0]               ostat_sym,
  output logic [15:0]               ostat_sat
);
  localparam int CW = $clog2(pFIFO_DEPTH) + 1;
  localparam logic signed [pIQ_W:0] LIM_HI = (pIQ_W+1)'(cLLR_MAX);
  localparam logic signed [pIQ_W:0] LIM_LO = -LIM_HI;

  logic                     rdy_reg;
  logic                     accept;
  logic signed [pIQ_W-1:0]  rail_in [2];
  llr_t                     rail_llr [2];
  logic [1:0]               rail_clip;
  logic signed [pIQ_W:0]    bias;

  logic                     s1_valid_reg;
  llr_pair_t                s1_pair_reg;
  logic [15:0]              stat_sym_reg;
  logic [15:0]              stat_sat_reg;

  ser_state_t               state_reg;
  logic                     oval_reg;
  llr_t                     odat_reg;

  llr_pair_t                head;
  llr_pair_t                head_next;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_empty;
  logic                     pop;
  logic                     next_avail;
  llr_pair_t                next_pair;
  logic [CW:0]              occ_next;

  assign accept     = bus.isample_val & rdy_reg;
  assign rail_in[0] = bus.isample_i;
  assign rail_in[1] = bus.isample_q;

  // Half an LSB of the shifted result, so the arithmetic shift rounds half up.
  assign bias = (bus.ishift == 3'd0) ? '0 : ((pIQ_W+1)'(1) <<< (bus.ishift - 3'd1));

  for (genvar gi = 0; gi < 2; gi++) begin : g_rail
    logic signed [pIQ_W:0] biased;
    logic signed [pIQ_W:0] scaled;

    assign biased        = {rail_in[gi][pIQ_W-1], rail_in[gi]} + bias;
    assign scaled        = biased >>> bus.ishift;
    assign rail_clip[gi] = (scaled > LIM_HI) || (scaled < LIM_LO);
    assign rail_llr[gi]  = (scaled > LIM_HI) ? llr_t'(cLLR_MAX)  :
                           (scaled < LIM_LO) ? llr_t'(-cLLR_MAX) :
                                               scaled[cLLR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_pair_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_pair_reg <= {rail_llr[0], rail_llr[1]};
      end
    end
  end

  // Clear beats a same-cycle increment; counters only update when something changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_sym_reg <= '0;
      stat_sat_reg <= '0;
    end else if (iclr_stat) begin
      stat_sym_reg <= '0;
      stat_sat_reg <= '0;
    end else if (accept) begin
      stat_sym_reg <= stat_add(stat_sym_reg, 2'd1);
      if (rail_clip != 2'b00) begin
        stat_sat_reg <= stat_add(stat_sat_reg, {1'b0, rail_clip[0]} + {1'b0, rail_clip[1]});
      end
    end
  end

  qpsk_llr_demapper_sym_fifo #(
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_valid_reg),
    .wr_data (s1_pair_reg),
    .rd_en   (pop),
    .rd_data (head),
    .rd_next (head_next),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign pop = (state_reg == S_Q) && bus.irdy;

  // The symbol behind the head is either already stored or being written this cycle.
  assign next_avail = (fifo_count > CW'(1)) || s1_valid_reg;
  assign next_pair  = (fifo_count > CW'(1)) ? head_next : s1_pair_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_I;
      oval_reg  <= 1'b0;
      odat_reg  <= '0;
    end else begin
      case (state_reg)
        S_I: begin
          if (!oval_reg) begin
            if (!fifo_empty) begin
              oval_reg <= 1'b1;
              odat_reg <= head.i;
            end
          end else if (bus.irdy) begin
            odat_reg  <= head.q;
            state_reg <= S_Q;
          end
        end
        S_Q: begin
          if (bus.irdy) begin
            state_reg <= S_I;
            oval_reg  <= next_avail;
            if (next_avail) begin
              odat_reg <= next_pair.i;
            end
          end
        end
        default: state_reg <= S_I;
      endcase
    end
  end

  // Ready is registered from next-cycle occupancy, counting the symbol still in stage 1.
  assign occ_next = (CW+1)'(fifo_count) + (CW+1)'(s1_valid_reg) + (CW+1)'(accept) - (CW+1)'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_reg <= 1'b0;
    end else begin
      rdy_reg <= occ_next < (CW+1)'(pFIFO_DEPTH);
    end
  end

  assign bus.osample_rdy = rdy_reg;
  assign bus.oval        = oval_reg;
  assign bus.odat        = pLLR_W'(odat_reg);
  assign ostat_sym       = stat_sym_reg;
  assign ostat_sat       = stat_sat_reg;

endmodule
